// File: rtl/simple_adder.sv
// Registered unsigned adder: SUM = A + B at WIDTH+1 bits, one clock of latency.
// No backpressure; clear beats in_valid, and async reset zeroes outputs.
module simple_adder #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  input  logic             clear,
  output logic [WIDTH:0]   SUM,
  output logic             out_valid
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] r_sum;
  logic           r_vld;

  // Zero-extend before adding so the carry lands in the MSB.
  assign w_sum = {1'b0, A} + {1'b0, B};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_vld <= 1'b0;
    end else if (clear) begin
      r_sum <= '0;
      r_vld <= 1'b0;
    end else if (in_valid) begin
      r_sum <= w_sum;
      r_vld <= 1'b1;
    end else begin
      r_vld <= 1'b0;
    end
  end

  assign SUM       = r_sum;
  assign out_valid = r_vld;

endmodule

// File: tb/tb_simple_adder.sv
// Self-checking bench for simple_adder: directed cases plus randomized traffic
// compared against an arithmetic reference model.
module tb_simple_adder;
  localparam int W = 2;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         in_valid;
  logic         clear;
  logic [W:0]   SUM;
  logic         out_valid;

  int checks;
  int errors;
  int m_sum;
  int m_vld;

  simple_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .in_valid (in_valid),
    .clear    (clear),
    .SUM      (SUM),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one set of inputs, take one edge, update the model, compare.
  task automatic step(input int a, input int b, input int v, input int c, input string tag);
    A        = W'(a);
    B        = W'(b);
    in_valid = v[0];
    clear    = c[0];
    @(posedge clk);
    #1;
    if (c != 0) begin
      m_sum = 0;
      m_vld = 0;
    end else if (v != 0) begin
      m_sum = a + b;
      m_vld = 1;
    end else begin
      m_vld = 0;
    end
    check({tag, "_sum"}, int'(SUM), m_sum);
    check({tag, "_vld"}, int'(out_valid), m_vld);
  endtask

  initial begin
    int a, b, v, c;
    checks   = 0;
    errors   = 0;
    m_sum    = 0;
    m_vld    = 0;
    rst_n    = 1'b0;
    A        = '0;
    B        = '0;
    in_valid = 1'b1;
    clear    = 1'b0;

    // Reset holds outputs low even with in_valid asserted and edges occurring.
    #2;
    check("rst_sum", int'(SUM), 0);
    check("rst_vld", int'(out_valid), 0);
    @(posedge clk);
    #1;
    check("rst_edge_sum", int'(SUM), 0);
    check("rst_edge_vld", int'(out_valid), 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Release alone yields no valid result.
    step(2, 1, 0, 0, "post_rst");

    // Basic sums including max with carry.
    step(0, 0, 1, 0, "zero");
    step(1, 1, 1, 0, "one");
    step(2, 2, 1, 0, "two");
    step(3, 3, 1, 0, "max");
    check("max_carry", int'(SUM[W]), 1);

    // Hold with in_valid low while operands wander.
    step(3, 1, 1, 0, "load4");
    for (int i = 0; i < 3; i++) step(i, 3 - i, 0, 0, "hold");
    check("hold_value", int'(SUM), 4);

    // Clear wins over in_valid.
    step(3, 3, 1, 0, "load6");
    step(1, 1, 1, 1, "clr_prio");

    // Async reset between edges.
    step(3, 3, 1, 0, "load6b");
    #2;
    rst_n = 1'b0;
    #1;
    m_sum = 0;
    m_vld = 0;
    check("async_sum", int'(SUM), 0);
    check("async_vld", int'(out_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 1, 0, 0, "after_async");

    // Exhaustive back-to-back sweep.
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        step(x, y, 1, 0, "sweep");

    // Random traffic, with mid-cycle operand churn that must not leak through.
    for (int i = 0; i < 300; i++) begin
      a = $urandom_range(0, 3);
      b = $urandom_range(0, 3);
      v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      c = ($urandom_range(0, 7) == 0) ? 1 : 0;
      step(a, b, v, c, "rand");
      if (i % 10 == 0) begin
        #2;
        A        = W'($urandom_range(0, 3));
        B        = W'($urandom_range(0, 3));
        in_valid = ~in_valid;
        clear    = 1'b0;
        #1;
        check("midcyc_sum", int'(SUM), m_sum);
        check("midcyc_vld", int'(out_valid), m_vld);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
